// File: rtl/ft245_tx_arbiter.sv
// ft245_tx_arbiter: round-robin arbiter that lets up to four byte
// requesters share one FT245 transmit simple interface, one packet at a time.
//
// Ports:
//   clk        - single clock, all state changes on the rising edge
//   rst        - asynchronous active-low reset
//   req_data   - requester i byte at [i*FT245_WIDTH +: FT245_WIDTH]
//   req_rdy    - requester i has a valid byte
//   req_last   - requester i byte ends its packet
//   req_ack    - requester i byte accepted (mirrors tx_ack_si for the grant)
//   tx_data_si - byte toward the FT245 interface
//   tx_rdy_si  - byte valid toward the FT245 interface
//   tx_ack_si  - FT245 interface accepted the byte
//   grant_id   - index of the current or last granted requester
//   busy       - high while a grant is active
module ft245_tx_arbiter #(
    parameter int FT245_WIDTH = 8,
    parameter int NUM_REQ     = 4,
    parameter int MAX_BURST   = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ*FT245_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_rdy,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ack,
    output logic [FT245_WIDTH-1:0]         tx_data_si,
    output logic                           tx_rdy_si,
    input  logic                           tx_ack_si,
    output logic [1:0]                     grant_id,
    output logic                           busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [1:0]             rr_ptr;
    logic [6:0]             burst_cnt;
    logic [1:0]             pick;
    logic                   any_rdy;
    logic [FT245_WIDTH-1:0] sel_data;
    logic                   sel_rdy;
    logic                   sel_last;
    logic                   xfer;
    logic                   limit_hit;
    logic                   burst_end;
    logic [1:0]             next_ptr;

    assign any_rdy = |req_rdy;

    // Circular search starting at rr_ptr. Walking offsets from the
    // farthest to the nearest lets the nearest ready requester win.
    always_comb begin
        int idx;
        idx  = 0;
        pick = rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (req_rdy[idx]) begin
                pick = 2'(idx);
            end
        end
    end

    // Signals of the currently granted requester.
    always_comb begin
        sel_data = '0;
        sel_rdy  = 1'b0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == 2'(i)) begin
                sel_data = req_data[i*FT245_WIDTH +: FT245_WIDTH];
                sel_rdy  = req_rdy[i];
                sel_last = req_last[i];
            end
        end
    end

    assign xfer = (state == S_GRANT) && sel_rdy && tx_ack_si;

    // The byte being transferred now would bring the count to the limit.
    assign limit_hit = (MAX_BURST != 0) &&
                       (({1'b0, burst_cnt} + 8'd1) == 8'(MAX_BURST));

    assign burst_end = xfer && (sel_last || limit_hit);

    assign next_ptr = (grant_id == 2'(NUM_REQ - 1)) ? 2'd0
                                                     : grant_id + 2'd1;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (any_rdy) begin
                    state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (burst_end) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Grant, round-robin pointer and burst counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_id  <= 2'd0;
            rr_ptr    <= 2'd0;
            burst_cnt <= 7'd0;
        end else begin
            if (state == S_IDLE && any_rdy) begin
                grant_id  <= pick;
                burst_cnt <= 7'd0;
            end else if (xfer) begin
                burst_cnt <= burst_cnt + 7'd1;
            end
            if (burst_end) begin
                rr_ptr <= next_ptr;
            end
        end
    end

    // Outputs: IDLE is silent, GRANT passes the granted requester through.
    always_comb begin
        busy       = (state == S_GRANT);
        tx_rdy_si  = 1'b0;
        tx_data_si = '0;
        req_ack    = '0;
        if (state == S_GRANT) begin
            tx_rdy_si  = sel_rdy;
            tx_data_si = sel_data;
            for (int i = 0; i < NUM_REQ; i++) begin
                req_ack[i] = (grant_id == 2'(i)) && tx_ack_si;
            end
        end
    end

endmodule

// File: tb/tb_ft245_tx_arbiter.sv
// tb_ft245_tx_arbiter: randomized requesters and FT245 acks, with a
// scoreboard of per-requester byte queues and a transaction-level model.
module tb_ft245_tx_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_rdy;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ack;
    logic [W-1:0]   tx_data_si;
    logic           tx_rdy_si;
    logic           tx_ack_si;
    logic [1:0]     grant_id;
    logic           busy;

    ft245_tx_arbiter #(
        .FT245_WIDTH(W),
        .NUM_REQ    (N),
        .MAX_BURST  (MB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_data  (req_data),
        .req_rdy   (req_rdy),
        .req_last  (req_last),
        .req_ack   (req_ack),
        .tx_data_si(tx_data_si),
        .tx_rdy_si (tx_rdy_si),
        .tx_ack_si (tx_ack_si),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } item_t;

    item_t exp_q[N][$];

    int n_pass  = 0;
    int n_chk   = 0;
    int n_xfer  = 0;
    int n_limit = 0;
    int n_rst   = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int pick_rr(int rr, logic [N-1:0] rdy);
        for (int k = 0; k < N; k++) begin
            if (rdy[(rr + k) % N]) begin
                return (rr + k) % N;
            end
        end
        return rr;
    endfunction

    // Monitor / reference model, sampled on the falling edge.
    bit    m_busy = 1'b0;
    int    m_g    = 0;
    int    m_rr   = 0;
    int    m_cnt  = 0;
    item_t it;

    always @(negedge clk) begin
        if (!rst) begin
            m_busy = 1'b0;
            m_g    = 0;
            m_rr   = 0;
            m_cnt  = 0;
            for (int i = 0; i < N; i++) begin
                exp_q[i].delete();
            end
        end else begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("grant_id", 32'(grant_id), 32'(m_g));
            if (!m_busy) begin
                chk("idle_tx_rdy", 32'(tx_rdy_si), 32'(0));
                chk("idle_req_ack", 32'(req_ack), 32'(0));
                chk("idle_tx_data", 32'(tx_data_si), 32'(0));
                if (|req_rdy) begin
                    m_g    = pick_rr(m_rr, req_rdy);
                    m_busy = 1'b1;
                    m_cnt  = 0;
                end
            end else begin
                chk("tx_rdy", 32'(tx_rdy_si), 32'(req_rdy[m_g]));
                chk("req_ack", 32'(req_ack),
                    tx_ack_si ? 32'(1 << m_g) : 32'(0));
                if (req_rdy[m_g] && tx_ack_si) begin
                    if (exp_q[m_g].size() == 0) begin
                        n_chk++;
                        $display("FAIL xfer_no_byte: got transfer, required none (req %0d) at %0t",
                                 m_g, $time);
                    end else begin
                        it = exp_q[m_g].pop_front();
                        chk("tx_data", 32'(tx_data_si), 32'(it.d));
                        n_xfer++;
                        m_cnt++;
                        if (it.l || m_cnt == MB) begin
                            if (!it.l) n_limit++;
                            m_busy = 1'b0;
                            m_rr   = (m_g + 1) % N;
                        end
                    end
                end else begin
                    chk("hold_data", 32'(tx_data_si),
                        32'(req_data[m_g*W +: W]));
                end
            end
        end
    end

    // Stimulus: requesters offer bytes, FT245 side acks randomly.
    initial begin
        logic [N-1:0] took;
        logic [N-1:0] pend;
        logic [W-1:0] cur_d [N];
        logic         cur_l [N];
        int           hold;
        int           next_rst;
        int           rst_hold;

        hold      = 0;
        next_rst  = 1500;
        rst_hold  = 0;
        took      = '0;
        pend      = '0;
        rst       = 1'b0;
        req_data  = '0;
        req_rdy   = '0;
        req_last  = '0;
        tx_ack_si = 1'b0;
        for (int i = 0; i < N; i++) begin
            cur_d[i] = '0;
            cur_l[i] = 1'b0;
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_tx_rdy", 32'(tx_rdy_si), 32'(0));
        chk("rst_req_ack", 32'(req_ack), 32'(0));
        chk("rst_tx_data", 32'(tx_data_si), 32'(0));
        chk("rst_grant_id", 32'(grant_id), 32'(0));
        rst = 1'b1;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            took = req_rdy & req_ack;
            @(posedge clk);
            #1;
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst = 1'b1;
            end else if (cyc >= next_rst && busy) begin
                rst = 1'b0;
                #1;
                chk("midrst_busy", 32'(busy), 32'(0));
                chk("midrst_tx_rdy", 32'(tx_rdy_si), 32'(0));
                chk("midrst_req_ack", 32'(req_ack), 32'(0));
                chk("midrst_tx_data", 32'(tx_data_si), 32'(0));
                chk("midrst_grant_id", 32'(grant_id), 32'(0));
                n_rst++;
                rst_hold = 2;
                next_rst += 1500;
                pend = '0;
                took = '0;
            end

            if (!rst) begin
                req_rdy  = '0;
                req_last = '0;
                req_data = '0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (took[i]) pend[i] = 1'b0;
                    if (!pend[i] && $urandom_range(3, 0) == 0) begin
                        cur_d[i] = W'($urandom);
                        cur_l[i] = ($urandom_range(5, 0) == 0);
                        exp_q[i].push_back('{cur_d[i], cur_l[i]});
                        pend[i] = 1'b1;
                    end
                    req_data[i*W +: W] = pend[i] ? cur_d[i] : '0;
                    req_last[i] = pend[i] && cur_l[i];
                    req_rdy[i]  = pend[i] && ($urandom_range(7, 0) != 0);
                end
            end

            if (hold > 0) begin
                tx_ack_si = 1'b0;
                hold--;
            end else if ($urandom_range(49, 0) == 0) begin
                tx_ack_si = 1'b0;
                hold = 9;
            end else begin
                tx_ack_si = ($urandom_range(3, 0) != 0);
            end
        end

        chk("xfers_seen", 32'(n_xfer > 300), 32'(1));
        chk("limit_bursts_seen", 32'(n_limit > 0), 32'(1));
        chk("resets_done", 32'(n_rst), 32'(2));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
